// File: rtl/apb_splitter_pkg.sv
// Shared types and helpers for the APB 1-to-N splitter.
package apb_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_split_state_t;

    // Width of the slave index field; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_timeout.sv
// ACCESS-phase watchdog: counts enabled cycles since the last clear and flags expiry.
module apb_timeout #(
    parameter int unsigned G_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (G_TIMEOUT == 0) begin : g_off
        logic unused_in;
        assign unused_in = ^{clk, rst, clear, enable};
        assign expired   = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(G_TIMEOUT + 1);

        logic [CW-1:0] cnt;

        // Saturates at the limit so expiry stays asserted until the next clear.
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                cnt <= '0;
            end else if (enable && !expired) begin
                cnt <= cnt + CW'(1);
            end
        end

        assign expired = (cnt == CW'(G_TIMEOUT));
    end

endmodule

// File: rtl/apb_splitter.sv
// Registered APB 1-to-N interconnect; unmapped addresses and hung slaves get a local PSLVERR.
module apb_splitter
    import apb_splitter_pkg::*;
#(
    parameter int unsigned G_REGWIDTH        = 32,
    parameter int unsigned G_ADDR_WIDTH      = 32,
    parameter int unsigned G_NUM_SLAVES      = 4,
    parameter int unsigned G_SLAVE_ADDR_BITS = 12,
    parameter int unsigned G_TIMEOUT         = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    // Upstream slave port
    input  logic                               s_apb_psel,
    input  logic                               s_apb_penable,
    input  logic                               s_apb_pwrite,
    input  logic [G_ADDR_WIDTH-1:0]            s_apb_paddr,
    input  logic [G_REGWIDTH-1:0]              s_apb_pwdata,
    input  logic [G_REGWIDTH/8-1:0]            s_apb_pstrb,
    output logic                               s_apb_pready,
    output logic                               s_apb_pslverr,
    output logic [G_REGWIDTH-1:0]              s_apb_prdata,
    // Downstream master ports
    output logic [G_NUM_SLAVES-1:0]            m_apb_psel,
    output logic                               m_apb_penable,
    output logic                               m_apb_pwrite,
    output logic [G_ADDR_WIDTH-1:0]            m_apb_paddr,
    output logic [G_REGWIDTH-1:0]              m_apb_pwdata,
    output logic [G_REGWIDTH/8-1:0]            m_apb_pstrb,
    input  logic [G_NUM_SLAVES-1:0]            m_apb_pready,
    input  logic [G_NUM_SLAVES-1:0]            m_apb_pslverr,
    input  logic [G_NUM_SLAVES*G_REGWIDTH-1:0] m_apb_prdata
);

    localparam int unsigned IDX_W  = idx_width(G_NUM_SLAVES);
    localparam int unsigned HI_LSB = G_SLAVE_ADDR_BITS + IDX_W;

    apb_split_state_t  state;
    logic [IDX_W-1:0]  idx_q;

    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_mapped;
    logic [G_NUM_SLAVES-1:0] dec_onehot;

    logic                  sel_ready;
    logic                  sel_err;
    logic [G_REGWIDTH-1:0] sel_rdata;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    // The upstream ENABLE phase carries no information this block needs.
    logic unused_penable;
    assign unused_penable = s_apb_penable;

    // Address decode: window index plus a check that no bits above it are set.
    assign dec_idx    = s_apb_paddr[G_SLAVE_ADDR_BITS +: IDX_W];
    assign dec_mapped = (32'(dec_idx) < G_NUM_SLAVES) && ((s_apb_paddr >> HI_LSB) == '0);

    always_comb begin
        dec_onehot = '0;
        for (int k = 0; k < G_NUM_SLAVES; k++) begin
            dec_onehot[k] = (dec_idx == IDX_W'(k));
        end
    end

    // Only the latched target's response is observed; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < G_NUM_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ready = m_apb_pready[k];
                sel_err   = m_apb_pslverr[k];
                sel_rdata = m_apb_prdata[k*G_REGWIDTH +: G_REGWIDTH];
            end
        end
    end

    assign tmo_clear  = (state == SETUP);
    assign tmo_enable = (state == ACCESS) && !sel_ready;

    apb_timeout #(
        .G_TIMEOUT (G_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx_q         <= '0;
            s_apb_pready  <= 1'b0;
            s_apb_pslverr <= 1'b0;
            s_apb_prdata  <= '0;
            m_apb_psel    <= '0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_paddr   <= '0;
            m_apb_pwdata  <= '0;
            m_apb_pstrb   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_apb_psel) begin
                        idx_q        <= dec_idx;
                        m_apb_paddr  <= s_apb_paddr;
                        m_apb_pwrite <= s_apb_pwrite;
                        m_apb_pwdata <= s_apb_pwdata;
                        m_apb_pstrb  <= s_apb_pstrb;
                        if (dec_mapped) begin
                            m_apb_psel    <= dec_onehot;
                            m_apb_penable <= 1'b0;
                            state         <= SETUP;
                        end else begin
                            s_apb_pready  <= 1'b1;
                            s_apb_pslverr <= 1'b1;
                            s_apb_prdata  <= '0;
                            state         <= RESP;
                        end
                    end
                end
                SETUP: begin
                    m_apb_penable <= 1'b1;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        m_apb_psel    <= '0;
                        m_apb_penable <= 1'b0;
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= sel_err;
                        s_apb_prdata  <= m_apb_pwrite ? '0 : sel_rdata;
                        state         <= RESP;
                    end else if (tmo_expired) begin
                        m_apb_psel    <= '0;
                        m_apb_penable <= 1'b0;
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= 1'b1;
                        s_apb_prdata  <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    s_apb_pready  <= 1'b0;
                    s_apb_pslverr <= 1'b0;
                    s_apb_prdata  <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_splitter.sv
// Scoreboard bench for apb_splitter with a configurable behavioural slave bank.
module tb_apb_splitter;

    localparam int HN = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_apb_psel, s_apb_penable, s_apb_pwrite;
    logic [31:0] s_apb_paddr, s_apb_pwdata;
    logic [3:0]  s_apb_pstrb;
    logic        s_apb_pready, s_apb_pslverr;
    logic [31:0] s_apb_prdata;
    logic [3:0]  m_apb_psel;
    logic        m_apb_penable, m_apb_pwrite;
    logic [31:0] m_apb_paddr, m_apb_pwdata;
    logic [3:0]  m_apb_pstrb;
    logic [3:0]  m_apb_pready, m_apb_pslverr;
    logic [127:0] m_apb_prdata;

    apb_splitter dut (
        .clk           (clk),
        .rst           (rst),
        .s_apb_psel    (s_apb_psel),
        .s_apb_penable (s_apb_penable),
        .s_apb_pwrite  (s_apb_pwrite),
        .s_apb_paddr   (s_apb_paddr),
        .s_apb_pwdata  (s_apb_pwdata),
        .s_apb_pstrb   (s_apb_pstrb),
        .s_apb_pready  (s_apb_pready),
        .s_apb_pslverr (s_apb_pslverr),
        .s_apb_prdata  (s_apb_prdata),
        .m_apb_psel    (m_apb_psel),
        .m_apb_penable (m_apb_penable),
        .m_apb_pwrite  (m_apb_pwrite),
        .m_apb_paddr   (m_apb_paddr),
        .m_apb_pwdata  (m_apb_pwdata),
        .m_apb_pstrb   (m_apb_pstrb),
        .m_apb_pready  (m_apb_pready),
        .m_apb_pslverr (m_apb_pslverr),
        .m_apb_prdata  (m_apb_prdata)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave bank: ready after waits[k] ACCESS cycles unless hung.
    int          waits [4];
    logic [31:0] srd   [4];
    logic        serr  [4];
    bit          hang  [4];
    bit          spur1;
    int          acc_cnt = 0;

    always @(posedge clk) acc_cnt <= (m_apb_penable && |m_apb_psel) ? acc_cnt + 1 : 0;

    always_comb begin
        m_apb_pready  = '0;
        m_apb_pslverr = '0;
        m_apb_prdata  = '0;
        for (int k = 0; k < 4; k++) begin
            m_apb_pready[k]          = m_apb_psel[k] && m_apb_penable && !hang[k] &&
                                       (acc_cnt == waits[k]);
            m_apb_pslverr[k]         = serr[k];
            m_apb_prdata[k*32 +: 32] = srd[k];
        end
        if (spur1) m_apb_pready[1] = 1'b1;
    end

    // Per-cycle history of downstream activity, sampled mid-cycle.
    logic [3:0]  h_psel  [HN];
    logic        h_pen   [HN];
    logic        h_pwr   [HN];
    logic        h_prdy  [HN];
    logic [31:0] h_paddr [HN];
    logic [31:0] h_pwd   [HN];
    logic [3:0]  h_pstrb [HN];

    always @(negedge clk) begin
        h_psel[cyc % HN]  = m_apb_psel;
        h_pen[cyc % HN]   = m_apb_penable;
        h_pwr[cyc % HN]   = m_apb_pwrite;
        h_prdy[cyc % HN]  = s_apb_pready;
        h_paddr[cyc % HN] = m_apb_paddr;
        h_pwd[cyc % HN]   = m_apb_pwdata;
        h_pstrb[cyc % HN] = m_apb_pstrb;
    end

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int          lat;
    logic [31:0] rd;
    logic        err;
    bit          ok;

    // Called just after a rising edge; that cycle is cycle 0 of the transfer.
    task automatic drive(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input int elat, input logic [31:0] erd,
                         input logic eerr, input bit push);
        exp_t x;
        s_apb_psel    = 1'b1;
        s_apb_penable = 1'b0;
        s_apb_pwrite  = wr;
        s_apb_paddr   = addr;
        s_apb_pwdata  = wd;
        s_apb_pstrb   = st;
        t0 = cyc;
        if (push) begin
            x.lat = elat; x.rdata = erd; x.err = eerr;
            sb.push_back(x);
        end
    endtask

    task automatic wait_resp(input int budget, output int l, output logic [31:0] r,
                             output logic er, output bit found);
        found = 0; l = -1; r = '0; er = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cyc - t0 == 1) s_apb_penable = 1'b1;
            if (s_apb_pready === 1'b1) begin
                l = cyc - t0; r = s_apb_prdata; er = s_apb_pslverr; found = 1;
                break;
            end
        end
        @(posedge clk); #1;
        s_apb_psel    = 1'b0;
        s_apb_penable = 1'b0;
    endtask

    task automatic pop_exp(input string nm);
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
            e.lat = -2; e.rdata = '0; e.err = 1'b0;
        end else begin
            e = sb.pop_front();
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_noresp: got no pready, required pready at cycle %0d", nm, e.lat);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({s_apb_pready, s_apb_pslverr, s_apb_prdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_up: got %0b/%0b/%h required 0", s_apb_pready, s_apb_pslverr,
                     s_apb_prdata);
        end
        n_cmp++;
        if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctl: got psel=%b en=%b wr=%b required 0", m_apb_psel,
                     m_apb_penable, m_apb_pwrite);
        end
        n_cmp++;
        if ({m_apb_paddr, m_apb_pwdata, m_apb_pstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h required 0", m_apb_paddr, m_apb_pwdata,
                     m_apb_pstrb);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write();
        int s;
        drive(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 32'h0, 1'b0, 1);
        s = t0;
        wait_resp(40, lat, rd, err, ok);
        pop_exp("wr");
        n_cmp++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL wr_lat: got %0d required %0d", lat, e.lat); end
        n_cmp++;
        if (err !== e.err) begin n_fail++; $display("FAIL wr_err: got %b required %b", err, e.err); end
        n_cmp++;
        if (rd !== e.rdata) begin n_fail++; $display("FAIL wr_rdata: got %h required %h", rd, e.rdata); end
        n_cmp++;
        if (h_psel[(s+1)%HN] !== 4'b0010 || h_pen[(s+1)%HN] !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_setup: got psel=%b en=%b required 0010/0", h_psel[(s+1)%HN],
                     h_pen[(s+1)%HN]);
        end
        n_cmp++;
        if (h_paddr[(s+1)%HN] !== 32'h0000_1004 || h_pwd[(s+1)%HN] !== 32'hDEAD_BEEF ||
            h_pstrb[(s+1)%HN] !== 4'hF || h_pwr[(s+1)%HN] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_fields: got %h/%h/%h/%b required 00001004/deadbeef/f/1",
                     h_paddr[(s+1)%HN], h_pwd[(s+1)%HN], h_pstrb[(s+1)%HN], h_pwr[(s+1)%HN]);
        end
        n_cmp++;
        if (h_psel[(s+2)%HN] !== 4'b0010 || h_pen[(s+2)%HN] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_access: got psel=%b en=%b required 0010/1", h_psel[(s+2)%HN],
                     h_pen[(s+2)%HN]);
        end
        n_cmp++;
        if (h_psel[(s+3)%HN] !== 4'b0000) begin
            n_fail++;
            $display("FAIL wr_release: got psel=%b required 0000", h_psel[(s+3)%HN]);
        end
    endtask

    task automatic test_read_wait();
        waits[3] = 3;
        drive(32'h0000_3010, 1'b0, 32'h0, 4'h0, 6, 32'h1234_5678, 1'b0, 1);
        wait_resp(40, lat, rd, err, ok);
        pop_exp("rd3");
        n_cmp++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL rd3_lat: got %0d required %0d", lat, e.lat); end
        n_cmp++;
        if (rd !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL rd3_resp: got %h/%b required %h/%b", rd, err, e.rdata, e.err);
        end
        waits[3] = 0;
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [2];
        int s;
        addrs[0] = 32'h0000_4000;
        addrs[1] = 32'h0001_0000;
        for (int i = 0; i < 2; i++) begin
            drive(addrs[i], 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b1, 1);
            s = t0;
            wait_resp(40, lat, rd, err, ok);
            pop_exp("unmap");
            n_cmp++;
            if (lat !== e.lat || err !== e.err || rd !== e.rdata) begin
                n_fail++;
                $display("FAIL unmap_resp[%0d]: got lat=%0d %h/%b required lat=%0d %h/%b", i,
                         lat, rd, err, e.lat, e.rdata, e.err);
            end
            n_cmp++;
            if (h_psel[(s+1)%HN] !== 4'b0000) begin
                n_fail++;
                $display("FAIL unmap_psel[%0d]: got %b required 0000", i, h_psel[(s+1)%HN]);
            end
        end
    endtask

    task automatic test_timeout();
        int s;
        hang[0] = 1'b1;
        drive(32'h0000_0010, 1'b0, 32'h0, 4'h0, 19, 32'h0, 1'b1, 1);
        s = t0;
        wait_resp(60, lat, rd, err, ok);
        pop_exp("tmo");
        n_cmp++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL tmo_lat: got %0d required %0d", lat, e.lat); end
        n_cmp++;
        if (rd !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL tmo_resp: got %h/%b required %h/%b", rd, err, e.rdata, e.err);
        end
        n_cmp++;
        if (h_psel[(s+18)%HN] !== 4'b0001 || h_psel[(s+19)%HN] !== 4'b0000) begin
            n_fail++;
            $display("FAIL tmo_psel: got %b then %b required 0001 then 0000",
                     h_psel[(s+18)%HN], h_psel[(s+19)%HN]);
        end
        drive(32'h0000_2020, 1'b0, 32'h0, 4'h0, 3, 32'h2222_2222, 1'b0, 1);
        wait_resp(40, lat, rd, err, ok);
        pop_exp("after_tmo");
        n_cmp++;
        if (lat !== e.lat || rd !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL after_tmo: got lat=%0d %h/%b required lat=%0d %h/%b", lat, rd, err,
                     e.lat, e.rdata, e.err);
        end
    endtask

    task automatic test_slverr_spurious();
        serr[2] = 1'b1; waits[2] = 1; spur1 = 1'b1;
        drive(32'h0000_2008, 1'b0, 32'h0, 4'h0, 4, 32'h2222_2222, 1'b1, 1);
        wait_resp(40, lat, rd, err, ok);
        pop_exp("slverr");
        n_cmp++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL slverr_lat: got %0d required %0d", lat, e.lat); end
        n_cmp++;
        if (rd !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL slverr_resp: got %h/%b required %h/%b", rd, err, e.rdata, e.err);
        end
        serr[2] = 1'b0; waits[2] = 0; spur1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int s;
        drive(32'h0000_3000, 1'b1, 32'hA5A5_0F0F, 4'h3, 3, 32'h0, 1'b0, 1);
        s = t0;
        wait_resp(40, lat, rd, err, ok);
        pop_exp("b2b_a");
        n_cmp++;
        if (lat !== e.lat || rd !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL b2b_a: got lat=%0d %h/%b required lat=%0d %h/%b", lat, rd, err,
                     e.lat, e.rdata, e.err);
        end
        drive(32'h0000_1000, 1'b0, 32'h0, 4'h0, 3, 32'h1111_1111, 1'b0, 1);
        wait_resp(40, lat, rd, err, ok);
        pop_exp("b2b_b");
        n_cmp++;
        if (lat !== e.lat || rd !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL b2b_b: got lat=%0d %h/%b required lat=%0d %h/%b", lat, rd, err,
                     e.lat, e.rdata, e.err);
        end
        n_cmp++;
        if (h_prdy[(s+4)%HN] !== 1'b0 || h_psel[(s+5)%HN] !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_spacing: got pready=%b psel=%b required 0/0010",
                     h_prdy[(s+4)%HN], h_psel[(s+5)%HN]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        waits[3] = 5;
        drive(32'h0000_3000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0);
        @(posedge clk); #1;
        s_apb_penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; s_apb_psel = 1'b0; s_apb_penable = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_apb_psel !== 4'b1000 || m_apb_penable !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got psel=%b en=%b required 1000/1", m_apb_psel,
                     m_apb_penable);
        end
        @(negedge clk);
        n_cmp++;
        if ({m_apb_psel, m_apb_penable, m_apb_paddr, s_apb_pready} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got psel=%b en=%b addr=%h rdy=%b required 0",
                     m_apb_psel, m_apb_penable, m_apb_paddr, s_apb_pready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_apb_pready === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_fail++; $display("FAIL rstmid_noresp: got %0d pready required 0", seen); end
        waits[3] = 0;
        @(posedge clk); #1;
        drive(32'h0000_3004, 1'b1, 32'h0BAD_F00D, 4'hC, 3, 32'h0, 1'b0, 1);
        wait_resp(40, lat, rd, err, ok);
        pop_exp("post_rst");
        n_cmp++;
        if (lat !== e.lat || rd !== e.rdata || err !== e.err) begin
            n_fail++;
            $display("FAIL post_rst: got lat=%0d %h/%b required lat=%0d %h/%b", lat, rd, err,
                     e.lat, e.rdata, e.err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_apb_psel = 1'b0; s_apb_penable = 1'b0; s_apb_pwrite = 1'b0;
        s_apb_paddr = '0; s_apb_pwdata = '0; s_apb_pstrb = '0;
        spur1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            waits[k] = 0; serr[k] = 1'b0; hang[k] = 1'b0;
        end
        srd[0] = 32'hA0A0_A0A0; srd[1] = 32'h1111_1111;
        srd[2] = 32'h2222_2222; srd[3] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        test_reset();
        test_write();
        test_read_wait();
        test_unmapped();
        test_timeout();
        test_slverr_spurious();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
